// File: rtl/pad_trigger_coincidence_pkg.sv
// Shared constants, candidate record and FSM states for the pad trigger coincidence slice.
// Optional macro TRIG_BCID_CHECK_EN adds a per-candidate layer-BCID mismatch flag.
package tds_trig_pkg;
    localparam int PAD_W    = 104;
    localparam int BCID_W   = 12;
    localparam int BCID_MSB = 115;
    localparam int BCID_LSB = 104;
    localparam int WORD_W   = BCID_MSB + 1;

    typedef struct packed {
`ifdef TRIG_BCID_CHECK_EN
        logic              err;
`endif
        logic [BCID_W-1:0] bcid;
        logic [PAD_W-1:0]  hitmap;
    } trig_cand_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} trig_state_t;

    // Out-of-range thresholds collapse onto the nearest meaningful layer count.
    function automatic logic [2:0] clamp_thr(input logic [2:0] thr);
        if (thr == 3'd0) return 3'd1;
        if (thr > 3'd4) return 3'd4;
        return thr;
    endfunction
endpackage

// File: rtl/pad_trigger_coincidence_if.sv
// Trigger candidate readout channel: valid/ready handshake carrying BCID, hitmap and error flag.
interface pad_trigger_coincidence_if;
    import tds_trig_pkg::*;

    logic              trig_valid;
    logic              trig_ready;
    logic [BCID_W-1:0] trig_bcid;
    logic [PAD_W-1:0]  trig_hitmap;
    logic              trig_bcid_err;

    modport master (
        output trig_valid, trig_bcid, trig_hitmap, trig_bcid_err,
        input  trig_ready
    );

    modport slave (
        input  trig_valid, trig_bcid, trig_hitmap, trig_bcid_err,
        output trig_ready
    );
endinterface

// File: rtl/pad_trigger_coincidence_fifo.sv
// First-word-fall-through candidate FIFO; head reads as zero while empty.
module trig_cand_fifo
    import tds_trig_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  trig_cand_t wdata,
    input  logic       pop,
    output trig_cand_t rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    trig_cand_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/pad_trigger_coincidence.sv
// N-of-4 layer pad coincidence with BCID tagging, buffered towards trigger readout.
// Optional macro TRIG_BCID_CHECK_EN enables the layer BCID consistency flag.
module pad_trigger_coincidence
    import tds_trig_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_W-1:0]     pad_data_0_aligned,
    input  logic [WORD_W-1:0]     pad_data_1_aligned,
    input  logic [WORD_W-1:0]     pad_data_2_aligned,
    input  logic [WORD_W-1:0]     pad_data_3_aligned,
    input  logic                  pad_data_valid_in,
    input  logic                  enable,
    input  logic [2:0]            coin_threshold,
    pad_trigger_coincidence_if.master trig,
    output logic                  fifo_full,
    output logic [CNT_W-1:0]      drop_cnt
);
    trig_state_t       state, state_nxt;
    logic              accept;
    logic [2:0]        thr;
    logic [PAD_W-1:0]  coin;
    logic              bcid_err;

    logic              vld_p1;
    logic [PAD_W-1:0]  coin_p1;
    logic [BCID_W-1:0] bcid_p1;
    logic              err_p1;

    logic              push;
    logic              fifo_empty;
    trig_cand_t        cand;
    trig_cand_t        head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN:   if (enable) state_nxt = RUN;
                     else if (fifo_empty && !vld_p1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == RUN) && pad_data_valid_in;
    assign thr    = clamp_thr(coin_threshold);

    always_comb begin
        logic [2:0] sum;
        coin = '0;
        for (int i = 0; i < PAD_W; i++) begin
            sum = {2'b00, pad_data_0_aligned[i]} + {2'b00, pad_data_1_aligned[i]}
                + {2'b00, pad_data_2_aligned[i]} + {2'b00, pad_data_3_aligned[i]};
            coin[i] = (sum >= thr);
        end
    end

`ifdef TRIG_BCID_CHECK_EN
    assign bcid_err = (pad_data_1_aligned[BCID_MSB:BCID_LSB] != pad_data_0_aligned[BCID_MSB:BCID_LSB])
                   || (pad_data_2_aligned[BCID_MSB:BCID_LSB] != pad_data_0_aligned[BCID_MSB:BCID_LSB])
                   || (pad_data_3_aligned[BCID_MSB:BCID_LSB] != pad_data_0_aligned[BCID_MSB:BCID_LSB]);
`else
    logic unused_bcid;
    assign unused_bcid = ^{pad_data_1_aligned[BCID_MSB:BCID_LSB],
                           pad_data_2_aligned[BCID_MSB:BCID_LSB],
                           pad_data_3_aligned[BCID_MSB:BCID_LSB]};
    assign bcid_err    = 1'b0;
`endif

    // ---- S1: registered coincidence ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            coin_p1 <= coin;
            bcid_p1 <= pad_data_0_aligned[BCID_MSB:BCID_LSB];
            err_p1  <= bcid_err;
        end
    end

    // ---- S2: candidate push into FIFO ----
    assign push        = vld_p1 && (|coin_p1);
    assign cand.bcid   = bcid_p1;
    assign cand.hitmap = coin_p1;
`ifdef TRIG_BCID_CHECK_EN
    assign cand.err    = err_p1;
`else
    logic unused_err;
    assign unused_err  = err_p1;
`endif

    trig_cand_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (cand),
        .pop   (trig.trig_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (push && fifo_full && !trig.trig_ready && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_W'(1);
    end

    assign trig.trig_valid  = !fifo_empty;
    assign trig.trig_bcid   = head.bcid;
    assign trig.trig_hitmap = head.hitmap;
`ifdef TRIG_BCID_CHECK_EN
    assign trig.trig_bcid_err = head.err;
`else
    assign trig.trig_bcid_err = 1'b0;
`endif
endmodule

// File: tb/tb_pad_trigger_coincidence.sv
// Self-checking bench: queue-based candidate model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_pad_trigger_coincidence;
    import tds_trig_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [WORD_W-1:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
    logic              valid_in = 1'b0;
    logic              enable = 1'b0;
    logic [2:0]        thr_in = 3'd1;
    logic              fifo_full;
    logic [CNT_W-1:0]  drop_cnt;

    pad_trigger_coincidence_if tif();

    pad_trigger_coincidence #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pad_data_0_aligned (w0),
        .pad_data_1_aligned (w1),
        .pad_data_2_aligned (w2),
        .pad_data_3_aligned (w3),
        .pad_data_valid_in  (valid_in),
        .enable             (enable),
        .coin_threshold     (thr_in),
        .trig               (tif.master),
        .fifo_full          (fifo_full),
        .drop_cnt           (drop_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [BCID_W-1:0] q_bcid[$];
    logic [PAD_W-1:0]  q_hit[$];
    logic              q_err[$];
    bit                run_m = 1'b0;
    bit                pend_vld = 1'b0;
    logic [PAD_W-1:0]  pend_hit = '0;
    logic [BCID_W-1:0] pend_bcid = '0;
    logic              pend_err = 1'b0;
    int unsigned       drop_m = 0;

    function automatic logic [PAD_W-1:0] model_coin(input logic [WORD_W-1:0] a, b, c, d,
                                                    input logic [2:0] t);
        logic [PAD_W-1:0] h;
        int need;
        int n;
        need = (t == 0) ? 1 : ((t > 4) ? 4 : int'(t));
        h = '0;
        for (int i = 0; i < PAD_W; i++) begin
            n = int'(a[i]) + int'(b[i]) + int'(c[i]) + int'(d[i]);
            h[i] = (n >= need);
        end
        return h;
    endfunction

    // Beats count only if enable was high at the previous edge; a full queue drops unless popped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_bcid.delete(); q_hit.delete(); q_err.delete();
            run_m = 1'b0; pend_vld = 1'b0; drop_m = 0;
        end else begin
            if (tif.trig_ready && q_bcid.size() > 0) begin
                void'(q_bcid.pop_front()); void'(q_hit.pop_front()); void'(q_err.pop_front());
            end
            if (pend_vld && pend_hit != '0) begin
                if (q_bcid.size() < DEPTH) begin
                    q_bcid.push_back(pend_bcid); q_hit.push_back(pend_hit); q_err.push_back(pend_err);
                end else if (drop_m != 32'hFFFF) begin
                    drop_m++;
                end
            end
            pend_vld = run_m && valid_in;
            if (pend_vld) begin
                pend_hit  = model_coin(w0, w1, w2, w3, thr_in);
                pend_bcid = w0[BCID_MSB:BCID_LSB];
`ifdef TRIG_BCID_CHECK_EN
                pend_err  = (w1[BCID_MSB:BCID_LSB] != w0[BCID_MSB:BCID_LSB])
                         || (w2[BCID_MSB:BCID_LSB] != w0[BCID_MSB:BCID_LSB])
                         || (w3[BCID_MSB:BCID_LSB] != w0[BCID_MSB:BCID_LSB]);
`else
                pend_err  = 1'b0;
`endif
            end
            run_m = enable;
        end
    end

    always @(negedge clk) begin
        check("m_valid", tif.trig_valid, q_bcid.size() > 0);
        check("m_full", fifo_full, q_bcid.size() == DEPTH);
        check("m_drop", drop_cnt, drop_m);
        if (q_bcid.size() > 0) begin
            check("m_bcid", tif.trig_bcid, q_bcid[0]);
            check("m_hitmap", tif.trig_hitmap, q_hit[0]);
            check("m_err", tif.trig_bcid_err, q_err[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [BCID_W-1:0] b0, b1, b2, b3,
                        input logic [PAD_W-1:0] h0, h1, h2, h3);
        w0 = {b0, h0}; w1 = {b1, h1}; w2 = {b2, h2}; w3 = {b3, h3};
        valid_in = 1'b1;
    endtask

    task automatic no_beat();
        valid_in = 1'b0;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    endtask

    function automatic logic [WORD_W-1:0] rnd_word(input logic [BCID_W-1:0] b);
        logic [PAD_W-1:0] h;
        h = '0;
        if ($urandom % 2 == 0) h[$urandom % 8] = 1'b1;
        if ($urandom % 8 == 0) h[PAD_W-1] = 1'b1;
        return {b, h};
    endfunction

    logic [PAD_W-1:0] b5;
    logic [PAD_W-1:0] b0h;
    logic [PAD_W-1:0] none;
    logic [BCID_W-1:0] expb;
    int pops;

    initial begin
        b5   = '0; b5[5] = 1'b1;
        b0h  = '0; b0h[0] = 1'b1;
        none = '0;
        tif.trig_ready = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_valid", tif.trig_valid, 0);
        check("rst_full", fifo_full, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_hitmap", tif.trig_hitmap, 0);
        rst_n = 1'b1;
        tick();

        // threshold 3: three layers on bit 5
        enable = 1'b1;
        tick();
        thr_in = 3'd3;
        beat(12'h123, 12'h123, 12'h123, 12'h123, b5, b5, b5, none);
        tick();
        no_beat();
        check("lat_not_yet", tif.trig_valid, 0);
        tick();
        check("thr3_valid", tif.trig_valid, 1);
        check("thr3_hitmap", tif.trig_hitmap, 128'h20);
        check("thr3_bcid", tif.trig_bcid, 12'h123);
        check("thr3_err", tif.trig_bcid_err, 0);
        tif.trig_ready = 1'b1;
        tick();
        tif.trig_ready = 1'b0;
        check("thr3_popped", tif.trig_valid, 0);

        // threshold 4, same stimulus: nothing
        thr_in = 3'd4;
        beat(12'h123, 12'h123, 12'h123, 12'h123, b5, b5, b5, none);
        tick();
        no_beat();
        tick(); tick();
        check("thr4_none", tif.trig_valid, 0);

        // threshold 0 clamps to 1
        thr_in = 3'd0;
        beat(12'h055, 12'h055, 12'h055, 12'h055, none, none, none, b0h);
        tick();
        no_beat();
        tick();
        check("thr0_valid", tif.trig_valid, 1);
        check("thr0_hitmap", tif.trig_hitmap, 128'h1);
        tif.trig_ready = 1'b1;
        tick();
        tif.trig_ready = 1'b0;

        // fill: 20 beats, no consumer
        thr_in = 3'd2;
        for (int i = 0; i < 20; i++) begin
            logic [PAD_W-1:0] h;
            h = '0; h[i] = 1'b1;
            beat(12'h200 + 12'(i), 12'h200 + 12'(i), 12'h200 + 12'(i), 12'h200 + 12'(i), h, h, h, h);
            tick();
        end
        no_beat();
        tick(); tick();
        check("fill_full", fifo_full, 1);
        check("fill_drop", drop_cnt, 4);
        check("fill_head", tif.trig_bcid, 12'h200);

        // push and pop on a full FIFO in the same cycle
        beat(12'h2AA, 12'h2AA, 12'h2AA, 12'h2AA, b5, b5, none, none);
        tick();
        no_beat();
        tif.trig_ready = 1'b1;
        tick();
        tif.trig_ready = 1'b0;
        check("pp_full", fifo_full, 1);
        check("pp_drop", drop_cnt, 4);
        check("pp_head", tif.trig_bcid, 12'h201);

        // drain in order
        tif.trig_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            expb = (k < 15) ? 12'h201 + 12'(k) : 12'h2AA;
            check("order_bcid", tif.trig_bcid, expb);
            tick();
        end
        tif.trig_ready = 1'b0;
        check("order_empty", tif.trig_valid, 0);

        // layer BCID disagreement
        thr_in = 3'd1;
        beat(12'h123, 12'h123, 12'h124, 12'h123, b5, none, none, none);
        tick();
        no_beat();
        tick();
`ifdef TRIG_BCID_CHECK_EN
        check("bcid_err", tif.trig_bcid_err, 1);
`else
        check("bcid_err", tif.trig_bcid_err, 0);
`endif
        tif.trig_ready = 1'b1;
        tick();
        tif.trig_ready = 1'b0;

        // drain on enable drop: beats in DRAIN are ignored
        for (int i = 0; i < 5; i++) begin
            beat(12'h300 + 12'(i), 12'h300 + 12'(i), 12'h300 + 12'(i), 12'h300 + 12'(i), b5, none, none, none);
            tick();
        end
        no_beat();
        enable = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            beat(12'h3F0, 12'h3F0, 12'h3F0, 12'h3F0, b5, b5, b5, b5);
            tick();
        end
        no_beat();
        tif.trig_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            if (tif.trig_valid) begin
                check("drain_bcid", tif.trig_bcid, 12'h300 + 12'(pops));
                pops++;
            end
            tick();
        end
        tif.trig_ready = 1'b0;
        check("drain_count", pops, 5);

        // reset mid-drain clears everything at once
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            beat(12'h400 + 12'(i), 12'h400, 12'h400, 12'h400, b5, none, none, none);
            tick();
        end
        no_beat();
        enable = 1'b0;
        tick(); tick();
        tif.trig_ready = 1'b1;
        tick(); tick();
        tif.trig_ready = 1'b0;
        check("pre_rst_valid", tif.trig_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", tif.trig_valid, 0);
        check("arst_full", fifo_full, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_bcid", tif.trig_bcid, 0);
        check("arst_hitmap", tif.trig_hitmap, 0);
        check("arst_err", tif.trig_bcid_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized traffic with periodic consumer stalls
        for (int c = 0; c < 3000; c++) begin
            logic [BCID_W-1:0] b;
            b = 12'($urandom);
            enable   = ($urandom % 16) != 0;
            valid_in = ($urandom % 4) != 0;
            thr_in   = 3'($urandom % 8);
            tif.trig_ready = ((c % 200) < 40) ? 1'b0 : (($urandom % 3) != 0);
            w0 = rnd_word(b);
            w1 = rnd_word(($urandom % 10 == 0) ? b + 12'd1 : b);
            w2 = rnd_word(b);
            w3 = rnd_word(($urandom % 10 == 0) ? b ^ 12'h800 : b);
            tick();
        end
        no_beat();
        tif.trig_ready = 1'b1;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
